psdsqrt_sched: RTL and testbench
================================

Name: psdsqrt_sched

Overview:
- Scheduler and sequencer for the psdsqrt square-root datapath.
- Arbitrates between two requesters with round-robin priority and latches the granted operand.
- Drives the datapath's one-cycle start and stop pulses, times the iterations, captures the result and returns it over a valid/ready result port tagged with the requester id.
- Sits between the system request logic and a single psdsqrt instance.

Parameters:
- NBITSIN, 32: operand width of each requester.
- K, 8: datapath extra fractional bits; datapath operand width is NBITSIN+K.
- NITER, (NBITSIN+K)/2 = 20: number of datapath iteration cycles between the start and stop pulses.
- CNTW, 8: width of the completed-operation counter.

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous reset, active high
- req0_valid  in  1  requester 0 has an operand
- req0_x  in  NBITSIN  requester 0 operand, unsigned
- req0_ready  out  1  requester 0 operand accepted this cycle
- req1_valid  in  1  requester 1 has an operand
- req1_x  in  NBITSIN  requester 1 operand, unsigned
- req1_ready  out  1  requester 1 operand accepted this cycle
- sq_start  out  1  datapath start pulse
- sq_stop  out  1  datapath stop pulse (loads datapath output register)
- sq_xin  out  NBITSIN+K  datapath operand: latched operand zero-extended, i.e. upper K bits 0
- sq_sqrt  in  NBITSIN/2  datapath result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  NBITSIN/2  captured square root
- res_id  out  1  requester id of res_data
- busy  out  1  high in every state except IDLE
- ops_count  out  CNTW  completed result handshakes, wraps modulo 2^CNTW

Behaviour:
- Reset (async, any time, including mid-operation):
  - FSM goes to IDLE.
  - All outputs are 0, and the latched operand, res_data, res_id and ops_count are 0.
  - The round-robin pointer is set so that req0 has priority.
- FSM states: IDLE, START, ITER, STOP, CAPT, RESP.
- IDLE:
  - Grant when any reqN_valid is high.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not served last is granted; after reset this is req0.
  - reqN_ready is combinational: IDLE AND granted to N. It is never high outside IDLE, and never high for both requesters.
  - On grant: latch the operand and the id, update the pointer, go to START.
- START:
  - sq_start = 1 for exactly this cycle.
  - sq_xin carries the latched operand; sq_xin is driven from the latch in all states.
  - Load the iteration counter with NITER-1, go to ITER.
- ITER:
  - Counter decrements each cycle.
  - When the counter = 0, go to STOP; the FSM spends exactly NITER cycles in ITER.
- STOP: sq_stop = 1 for exactly this cycle, go to CAPT.
- CAPT: register sq_sqrt into res_data and the latched id into res_id, go to RESP.
- RESP:
  - res_valid = 1; res_data and res_id are held stable until the handshake.
  - On res_valid & res_ready: ops_count increments, go to IDLE.
  - res_ready already high on the first RESP cycle completes the handshake in that cycle.
- Latency: a request accepted at cycle T gives sq_start at T+1, sq_stop at T+NITER+2, and res_valid from T+NITER+4 (T+24 at defaults).
- Minimum initiation interval: NITER+5 cycles.
- No acceptance of a new request occurs in the cycle of the result handshake; acceptance happens only in IDLE.
- Backpressure: while in RESP, no new request is accepted, and reqN_ready stays 0 regardless of reqN_valid.
- A requester dropping valid before a grant is legal; nothing is latched.
- ops_count wraps from 2^CNTW-1 to 0 and never saturates.
- sq_start and sq_stop are never high in the same cycle, and are never high outside START and STOP respectively.

Test Plan:
- Single request: after reset, req0_x=144 held valid at T, res_ready=1 -> req0_ready=1 at T, sq_start at T+1 only, sq_stop at T+22 only, res_valid at T+24 with res_data=12 and res_id=0, ops_count=1.
- Simultaneous requests: req0_x=81 and req1_x=10000 both valid after reset -> req0 served first (res_data=9, id 0), then req1 (res_data=100, id 1). Repeat with both valid again -> req0 granted first, since req1 was served last.
- Backpressure: res_ready=0 for 5 cycles after res_valid, req1_valid=1 throughout -> res_data and res_id stable, req1_ready=0, busy=1, ops_count unchanged; res_ready=1 -> handshake, req1 granted in the next IDLE cycle.
- Reset mid-operation: assert reset asynchronously during ITER (cycle T+10) -> outputs 0 immediately, no sq_stop pulse, FSM in IDLE after release; a new req1_x=49 request then completes with res_data=7.
- Edge operands: req0_x=0 -> res_data=0; req0_x=0xFFFFFFFF -> sq_xin upper 8 bits 0 and res_data equals the value the datapath produces for that operand (golden model).
- Counter wrap: 256 consecutive completed operations -> ops_count returns to 0 after the 256th handshake, then 1 after the 257th.

Source files
------------

// File: rtl/psdsqrt_sched_if.sv
// ----------------------------------------------------------------------------
// psdsqrt_sched_if
//   Request/result bus of the psdsqrt scheduler.
//   master : system side (drives operands, accepts results)
//   slave  : scheduler side (accepts operands, presents results)
//   Signals:
//     req0_valid/req0_x/req0_ready : requester 0 operand handshake
//     req1_valid/req1_x/req1_ready : requester 1 operand handshake
//     res_valid/res_ready          : result handshake
//     res_data/res_id              : square root and the id of its requester
// ----------------------------------------------------------------------------
interface psdsqrt_sched_if #(
    parameter int NBITSIN = 32
);
    logic                   req0_valid;
    logic [NBITSIN-1:0]     req0_x;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [NBITSIN-1:0]     req1_x;
    logic                   req1_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [NBITSIN/2-1:0]   res_data;
    logic                   res_id;

    modport master (
        output req0_valid, req0_x, req1_valid, req1_x, res_ready,
        input  req0_ready, req1_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req0_valid, req0_x, req1_valid, req1_x, res_ready,
        output req0_ready, req1_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/psdsqrt_sched.sv
// ----------------------------------------------------------------------------
// psdsqrt_sched
//   Scheduler/sequencer for one psdsqrt square-root datapath. Round-robin
//   arbitration between two requesters, operand latch, start/stop pulse
//   generation with an iteration down-counter, result capture and a
//   valid/ready result port tagged with the requester id.
//
//   Ports:
//     clock        rising-edge clock
//     reset        asynchronous reset, active high
//     bus          request/result interface (slave side)
//     sq_start_o   one-cycle datapath start pulse
//     sq_stop_o    one-cycle datapath stop pulse (loads datapath output)
//     sq_xin_o     datapath operand, latched operand zero-extended by K bits
//     sq_sqrt_i    datapath result
//     busy_o       high in every state except IDLE
//     ops_count_o  completed result handshakes, wraps
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for a request; reqN_ready may be high
//   S_START | sq_start pulse, iteration counter loaded
//   S_ITER  | datapath iterating, counter runs down to zero
//   S_STOP  | sq_stop pulse, datapath loads its output register
//   S_CAPT  | datapath result and id registered
//   S_RESP  | res_valid high, waiting for res_ready
// ----------------------------------------------------------------------------
module psdsqrt_sched #(
    parameter int NBITSIN = 32,
    parameter int K       = 8,
    parameter int NITER   = (NBITSIN + K) / 2,
    parameter int CNTW    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    psdsqrt_sched_if.slave         bus,
    output logic                   sq_start_o,
    output logic                   sq_stop_o,
    output logic [NBITSIN+K-1:0]   sq_xin_o,
    input  logic [NBITSIN/2-1:0]   sq_sqrt_i,
    output logic                   busy_o,
    output logic [CNTW-1:0]        ops_count_o
);

    localparam int ITW = (NITER > 1) ? $clog2(NITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ITER,
        S_STOP,
        S_CAPT,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic                   last_q;      // id served last; 1 after reset so req0 wins a tie
    logic                   id_q;
    logic [NBITSIN-1:0]     operand_q;
    logic [ITW-1:0]         iter_q;
    logic                   sq_start_q;
    logic                   sq_stop_q;
    logic                   busy_q;
    logic                   res_valid_q;
    logic [NBITSIN/2-1:0]   res_data_q;
    logic                   res_id_q;
    logic [CNTW-1:0]        ops_q;
    logic [CNTW-1:0]        ops_d;

    logic                   gnt0;
    logic                   gnt1;

    // Round robin: a lone requester always wins, a tie goes to the one not
    // served last.
    assign gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
    assign gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

    // Ready is gated by reset so no output is high while reset is asserted.
    assign bus.req0_ready = (state_q == S_IDLE) & ~reset & gnt0;
    assign bus.req1_ready = (state_q == S_IDLE) & ~reset & gnt1;

    assign ops_d = ops_q + CNTW'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            operand_q   <= '0;
            iter_q      <= '0;
            sq_start_q  <= 1'b0;
            sq_stop_q   <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            ops_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt0 | gnt1) begin
                        operand_q  <= gnt1 ? bus.req1_x : bus.req0_x;
                        id_q       <= gnt1;
                        last_q     <= gnt1;
                        sq_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    sq_start_q <= 1'b0;
                    iter_q     <= ITW'(NITER - 1);
                    state_q    <= S_ITER;
                end
                S_ITER: begin
                    if (iter_q == '0) begin
                        sq_stop_q <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        iter_q <= iter_q - ITW'(1);
                    end
                end
                S_STOP: begin
                    sq_stop_q <= 1'b0;
                    state_q   <= S_CAPT;
                end
                S_CAPT: begin
                    res_data_q  <= sq_sqrt_i;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ops_q       <= ops_d;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    sq_start_q  <= 1'b0;
                    sq_stop_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sq_start_o    = sq_start_q;
    assign sq_stop_o     = sq_stop_q;
    assign sq_xin_o      = {{K{1'b0}}, operand_q};
    assign busy_o        = busy_q;
    assign ops_count_o   = ops_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_psdsqrt_sched.sv
// ----------------------------------------------------------------------------
// tb_psdsqrt_sched
//   Bench for psdsqrt_sched. A behavioural datapath answers sq_stop with the
//   integer square root of the operand it was given; expected results are
//   queued as requests are driven and compared at each result handshake.
// ----------------------------------------------------------------------------
module tb_psdsqrt_sched;

    localparam int NBITSIN = 32;
    localparam int K       = 8;
    localparam int NITER   = (NBITSIN + K) / 2;
    localparam int CNTW    = 8;

    typedef struct {
        logic                 id;
        logic [NBITSIN/2-1:0] val;
        logic [NBITSIN-1:0]   x;
    } exp_t;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   sq_start;
    logic                   sq_stop;
    logic [NBITSIN+K-1:0]   sq_xin;
    logic [NBITSIN/2-1:0]   sq_sqrt = '0;
    logic                   busy;
    logic [CNTW-1:0]        ops_count;

    psdsqrt_sched_if #(.NBITSIN(NBITSIN)) bus();

    psdsqrt_sched #(
        .NBITSIN (NBITSIN),
        .K       (K),
        .NITER   (NITER),
        .CNTW    (CNTW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .sq_start_o  (sq_start),
        .sq_stop_o   (sq_stop),
        .sq_xin_o    (sq_xin),
        .sq_sqrt_i   (sq_sqrt),
        .busy_o      (busy),
        .ops_count_o (ops_count)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_ops = 0;
    int   acc_cyc = -1000;
    logic rv_prev = 1'b0;
    exp_t sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [NBITSIN/2-1:0] isqrt(input logic [NBITSIN-1:0] x);
        logic [NBITSIN/2-1:0] r;
        r = '0;
        for (int b = NBITSIN/2 - 1; b >= 0; b--) begin
            logic [NBITSIN/2-1:0] t;
            logic [NBITSIN-1:0]   sq;
            t  = r | (NBITSIN/2)'(1 << b);
            sq = NBITSIN'(t) * NBITSIN'(t);
            if (sq <= x) r = t;
        end
        return r;
    endfunction

    // Behavioural datapath: output register loads on sq_stop.
    always @(posedge clock) begin
        if (sq_stop) sq_sqrt <= isqrt(sq_xin[NBITSIN-1:0]);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: timing of pulses relative to acceptance, and scoreboard pop.
    always @(negedge clock) begin : mon
        exp_t e;
        #2;
        if (!reset) begin
            if ((bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready))
                acc_cyc = cyc;
            if (bus.req0_ready & bus.req1_ready)
                chk("rdy_excl", {bus.req0_ready, bus.req1_ready}, 2'b00);
            if (sq_start) begin
                chk("start_lat", 64'(cyc - acc_cyc), 64'(1));
                chk("xin_hi", 64'(sq_xin[NBITSIN+K-1:NBITSIN]), 64'(0));
                if (sb.size() > 0) chk("xin_lo", 64'(sq_xin[NBITSIN-1:0]), 64'(sb[0].x));
            end
            if (sq_stop) chk("stop_lat", 64'(cyc - acc_cyc), 64'(NITER + 2));
            if (bus.res_valid & ~rv_prev) chk("res_lat", 64'(cyc - acc_cyc), 64'(NITER + 4));
            if (bus.res_valid & bus.res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 64'(sb.size()), 64'(1));
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 64'(bus.res_data), 64'(e.val));
                    chk("res_id", 64'(bus.res_id), 64'(e.id));
                    exp_ops++;
                end
            end
        end
        rv_prev = bus.res_valid;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic id, input logic [NBITSIN-1:0] x);
        exp_t e;
        e.id  = id;
        e.val = isqrt(x);
        e.x   = x;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [NBITSIN-1:0] x);
        if (id) begin
            bus.req1_valid = v;
            bus.req1_x     = x;
        end else begin
            bus.req0_valid = v;
            bus.req0_x     = x;
        end
    endtask

    // Waits (bounded) for requester id to see ready; returns at a point
    // between the accepting negedge and the next posedge.
    task automatic wait_ready(input logic id, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (id ? bus.req1_ready : bus.req0_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    task automatic drive_one(input logic id, input logic [NBITSIN-1:0] x);
        push_exp(id, x);
        set_req(id, 1'b1, x);
        wait_ready(id, "grant_wait");
        @(negedge clock);
        set_req(id, 1'b0, '0);
    endtask

    task automatic drive_both(input logic [NBITSIN-1:0] x0, input logic [NBITSIN-1:0] x1,
                              input logic first);
        push_exp(first, first ? x1 : x0);
        push_exp(~first, first ? x0 : x1);
        set_req(1'b0, 1'b1, x0);
        set_req(1'b1, 1'b1, x1);
        wait_ready(first, "rr_first");
        chk("rr_other_idle", 64'(first ? bus.req0_ready : bus.req1_ready), 64'(0));
        @(negedge clock);
        set_req(first, 1'b0, '0);
        wait_ready(~first, "rr_second");
        @(negedge clock);
        set_req(~first, 1'b0, '0);
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            #1;
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_wait", 64'(ok), 64'(1));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clock);
        exp_ops = 0;
        reset = 1'b0;
    endtask

    initial begin
        int stops;
        logic ok;
        bus.req0_valid = 1'b0;
        bus.req0_x     = '0;
        bus.req1_valid = 1'b0;
        bus.req1_x     = '0;
        bus.res_ready  = 1'b1;

        // Reset values, with a request pending to show ready stays low.
        repeat (2) @(negedge clock);
        bus.req0_valid = 1'b1;
        bus.req0_x     = 32'd144;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_start", 64'(sq_start), 64'(0));
        chk("rst_stop", 64'(sq_stop), 64'(0));
        chk("rst_xin", 64'(sq_xin), 64'(0));
        chk("rst_rvalid", 64'(bus.res_valid), 64'(0));
        chk("rst_rdata", 64'(bus.res_data), 64'(0));
        chk("rst_rid", 64'(bus.res_id), 64'(0));
        chk("rst_ops", 64'(ops_count), 64'(0));
        chk("rst_rdy0", 64'(bus.req0_ready), 64'(0));
        chk("rst_rdy1", 64'(bus.req1_ready), 64'(0));
        bus.req0_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // Single request.
        @(negedge clock);
        drive_one(1'b0, 32'd144);
        wait_idle();
        chk("ops_single", 64'(ops_count), 64'(exp_ops % 256));

        // Simultaneous requests and round-robin.
        apply_reset();
        drive_both(32'd81, 32'd10000, 1'b0);
        wait_idle();
        drive_both(32'd1, 32'd4, 1'b0);
        wait_idle();
        drive_one(1'b0, 32'd25);
        wait_idle();
        drive_both(32'd36, 32'd64, 1'b1);
        wait_idle();
        chk("ops_rr", 64'(ops_count), 64'(exp_ops % 256));

        // Backpressure with requester 1 waiting.
        bus.res_ready = 1'b0;
        drive_one(1'b0, 32'd10000);
        push_exp(1'b1, 32'd2401);
        set_req(1'b1, 1'b1, 32'd2401);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            #1;
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("bp_rv_wait", 64'(ok), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 64'(bus.res_data), 64'(100));
            chk("bp_id", 64'(bus.res_id), 64'(0));
            chk("bp_rdy1", 64'(bus.req1_ready), 64'(0));
            chk("bp_busy", 64'(busy), 64'(1));
            chk("bp_ops", 64'(ops_count), 64'(exp_ops % 256));
            @(negedge clock);
            #1;
        end
        bus.res_ready = 1'b1;
        @(negedge clock);
        #1;
        chk("bp_grant1", 64'(bus.req1_ready), 64'(1));
        @(negedge clock);
        set_req(1'b1, 1'b0, '0);
        wait_idle();

        // Asynchronous reset in the middle of ITER.
        drive_one(1'b0, 32'd1000);
        for (int i = 0; i < 30 && cyc < acc_cyc + 10; i++) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_busy", 64'(busy), 64'(0));
        chk("mr_start", 64'(sq_start), 64'(0));
        chk("mr_stop", 64'(sq_stop), 64'(0));
        chk("mr_xin", 64'(sq_xin), 64'(0));
        chk("mr_rvalid", 64'(bus.res_valid), 64'(0));
        chk("mr_ops", 64'(ops_count), 64'(0));
        repeat (2) @(negedge clock);
        sb.delete();
        exp_ops = 0;
        reset = 1'b0;
        stops = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            #1;
            if (sq_stop) stops++;
        end
        chk("mr_no_stop", 64'(stops), 64'(0));
        chk("mr_idle", 64'(busy), 64'(0));
        drive_one(1'b1, 32'd49);
        wait_idle();
        chk("mr_ops_after", 64'(ops_count), 64'(exp_ops % 256));

        // Edge operands.
        drive_one(1'b0, 32'd0);
        wait_idle();
        drive_one(1'b0, 32'hFFFF_FFFF);
        wait_idle();

        // Completed-operation counter wrap.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            drive_one(1'(i % 2), $urandom);
            wait_idle();
            if (i == 254) chk("ops_255", 64'(ops_count), 64'(exp_ops % 256));
        end
        chk("ops_wrap0", 64'(ops_count), 64'(exp_ops % 256));
        drive_one(1'b1, 32'd12345);
        wait_idle();
        chk("ops_wrap1", 64'(ops_count), 64'(exp_ops % 256));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
